// File: rtl/pc_unit.sv
// Program-counter unit: fetch address generation with a memory-ready handshake,
// buffered redirects under stall, trap vectoring and halt/resume. Falling-edge state.
module pc_unit #(
   parameter int             W         = 32,
   parameter int             INC       = 4,
   parameter logic [W-1:0]   RESET_VEC = W'(32'h00000000),
   parameter logic [W-1:0]   TRAP_VEC  = W'(32'h00000080),
   parameter int             BOOT_CYC  = 2,
   parameter int             CNT_W     = 32
) (
   input  logic             Clk,
   input  logic             Clrn,
   input  logic             stall,
   input  logic             imem_ready,
   input  logic             br_valid,
   input  logic [W-1:0]     br_target,
   input  logic             trap_valid,
   input  logic             halt,
   input  logic             resume,
   output logic [W-1:0]     pc_out,
   output logic             imem_req,
   output logic             pend_valid,
   output logic             misalign,
   output logic [W-1:0]     epc,
   output logic [CNT_W-1:0] fetch_cnt
);

   localparam int           BW        = (BOOT_CYC > 1) ? $clog2(BOOT_CYC) : 1;
   localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYC - 1);
   localparam logic [W-1:0] INC_MASK  = W'(INC - 1);
   localparam logic [W-1:0] INC_STEP  = W'(INC);

   typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

   state_t          state, state_nx;
   logic [BW-1:0]   boot_cnt, boot_nx;
   logic [W-1:0]    pc_nx, epc_nx, pend_tgt, tgt_nx;
   logic            pend_nx, mis_nx;
   logic [CNT_W-1:0] cnt_nx;
   logic            adv, mis;

   assign adv      = (state == RUN) & ~stall & imem_ready;
   assign mis      = br_valid & (|(br_target & INC_MASK));
   assign imem_req = (state == RUN) & ~stall;

   always_ff @(negedge Clk) begin
      if (!Clrn) begin
         state      <= BOOT;
         boot_cnt   <= '0;
         pc_out     <= RESET_VEC;
         pend_valid <= 1'b0;
         pend_tgt   <= '0;
         misalign   <= 1'b0;
         epc        <= '0;
         fetch_cnt  <= '0;
      end else begin
         state      <= state_nx;
         boot_cnt   <= boot_nx;
         pc_out     <= pc_nx;
         pend_valid <= pend_nx;
         pend_tgt   <= tgt_nx;
         misalign   <= mis_nx;
         epc        <= epc_nx;
         fetch_cnt  <= cnt_nx;
      end
   end

   // Traps and misaligned redirects outrank halt; otherwise halt still lets this edge's PC move.
   always_comb begin
      state_nx = state;
      boot_nx  = boot_cnt;
      pc_nx    = pc_out;
      pend_nx  = pend_valid;
      tgt_nx   = pend_tgt;
      mis_nx   = 1'b0;
      epc_nx   = epc;
      cnt_nx   = fetch_cnt;
      case (state)
         BOOT: begin
            if (boot_cnt == BOOT_LAST) begin
               state_nx = RUN;
            end else begin
               boot_nx = boot_cnt + BW'(1);
            end
         end
         RUN: begin
            if (adv) begin
               cnt_nx = fetch_cnt + CNT_W'(1);
            end
            if (trap_valid) begin
               pc_nx   = TRAP_VEC;
               epc_nx  = pc_out;
               pend_nx = 1'b0;
            end else if (mis) begin
               pc_nx   = TRAP_VEC;
               epc_nx  = br_target;
               mis_nx  = 1'b1;
               pend_nx = 1'b0;
            end else begin
               if (halt) begin
                  state_nx = HALT;
               end
               if (br_valid && adv) begin
                  pc_nx   = br_target;
                  pend_nx = 1'b0;
               end else if (br_valid) begin
                  pend_nx = 1'b1;
                  tgt_nx  = br_target;
               end else if (pend_valid && adv) begin
                  pc_nx   = pend_tgt;
                  pend_nx = 1'b0;
               end else if (adv) begin
                  pc_nx = pc_out + INC_STEP;
               end
            end
         end
         HALT: begin
            if (trap_valid) begin
               pc_nx    = TRAP_VEC;
               epc_nx   = pc_out;
               pend_nx  = 1'b0;
               state_nx = RUN;
            end else if (resume) begin
               state_nx = RUN;
            end
         end
         default: state_nx = BOOT;
      endcase
   end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus randomized traffic, all checked
// against a behavioural model of the fetch-address rules.
module tb_pc_unit;

   localparam int          INC      = 4;
   localparam int          BOOT_CYC = 2;
   localparam logic [31:0] RST_PC   = 32'h0;
   localparam logic [31:0] TRAP_PC  = 32'h80;

   logic        Clk, Clrn, stall, imem_ready, br_valid, trap_valid, halt, resume;
   logic [31:0] br_target, pc_out, epc, fetch_cnt;
   logic        imem_req, pend_valid, misalign;

   int compared   = 0;
   int mismatched = 0;

   // behavioural model
   logic [31:0] m_pc, m_epc, m_tgt, m_cnt;
   bit          m_pend, m_mis, m_halted;
   int          m_boot_left;

   pc_unit #(.W(32), .INC(INC), .RESET_VEC(RST_PC), .TRAP_VEC(TRAP_PC),
             .BOOT_CYC(BOOT_CYC), .CNT_W(32)) dut (
      .Clk(Clk), .Clrn(Clrn), .stall(stall), .imem_ready(imem_ready),
      .br_valid(br_valid), .br_target(br_target), .trap_valid(trap_valid),
      .halt(halt), .resume(resume), .pc_out(pc_out), .imem_req(imem_req),
      .pend_valid(pend_valid), .misalign(misalign), .epc(epc), .fetch_cnt(fetch_cnt)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic bit modelRunning();
      return (m_boot_left == 0) && !m_halted;
   endfunction

   task automatic modelReset();
      m_pc = RST_PC; m_epc = '0; m_tgt = '0; m_cnt = '0;
      m_pend = 0; m_mis = 0; m_halted = 0; m_boot_left = BOOT_CYC;
   endtask

   // One falling edge of the model, using the inputs currently applied.
   task automatic modelEdge();
      bit adv, bad;
      if (!Clrn) begin
         modelReset();
         return;
      end
      m_mis = 0;
      if (m_boot_left > 0) begin
         m_boot_left--;
      end else if (m_halted) begin
         if (trap_valid) begin
            m_epc = m_pc; m_pc = TRAP_PC; m_pend = 0; m_halted = 0;
         end else if (resume) begin
            m_halted = 0;
         end
      end else begin
         adv = !stall && imem_ready;
         bad = br_valid && ((br_target % INC) != 0);
         if (adv) m_cnt = m_cnt + 1;
         if (trap_valid) begin
            m_epc = m_pc; m_pc = TRAP_PC; m_pend = 0;
         end else if (bad) begin
            m_epc = br_target; m_pc = TRAP_PC; m_pend = 0; m_mis = 1;
         end else begin
            if (halt) m_halted = 1;
            if (br_valid && adv) begin
               m_pc = br_target; m_pend = 0;
            end else if (br_valid) begin
               m_tgt = br_target; m_pend = 1;
            end else if (m_pend && adv) begin
               m_pc = m_tgt; m_pend = 0;
            end else if (adv) begin
               m_pc = m_pc + INC;
            end
         end
      end
   endtask

   task automatic checkRegs();
      checkOutput("pc_out", pc_out, m_pc);
      checkOutput("epc", epc, m_epc);
      checkOutput("pend_valid", pend_valid, m_pend);
      checkOutput("misalign", misalign, m_mis);
      checkOutput("fetch_cnt", fetch_cnt, m_cnt);
   endtask

   // Drive one cycle of inputs, check the combinational request, clock, check registers.
   task automatic applyStimulus(input logic clr, stl, rdy, bv, input logic [31:0] bt,
                                input logic tv, hl, rs);
      Clrn = clr; stall = stl; imem_ready = rdy; br_valid = bv; br_target = bt;
      trap_valid = tv; halt = hl; resume = rs;
      #1;
      checkOutput("imem_req", imem_req, modelRunning() && !stl);
      @(negedge Clk);
      modelEdge();
      #2;
      checkRegs();
   endtask

   initial begin
      Clrn = 0; stall = 0; imem_ready = 1; br_valid = 0; br_target = '0;
      trap_valid = 0; halt = 0; resume = 0;
      @(negedge Clk);
      modelEdge();
      #2;
      checkRegs();

      // boot: two edges with no request, then sequential fetch
      for (int i = 0; i < 2; i++) begin
         applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
         checkOutput("boot_pc", pc_out, 32'h0);
      end
      applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
      checkOutput("seq_pc4", pc_out, 32'h4);
      applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
      applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
      checkOutput("seq_pcC", pc_out, 32'hC);
      checkOutput("seq_cnt3", fetch_cnt, 32'd3);

      // stall and not-ready both hold the PC
      applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("hold_pc", pc_out, 32'h10);
      checkOutput("hold_cnt", fetch_cnt, 32'd4);

      // buffered redirect, newest target wins; then a fresh redirect on release
      applyStimulus(1, 0, 1, 1, 32'h20, 0, 0, 0);
      applyStimulus(1, 1, 1, 1, 32'h100, 0, 0, 0);
      applyStimulus(1, 1, 1, 1, 32'h200, 0, 0, 0);
      checkOutput("buf_pend", pend_valid, 1'b1);
      applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
      checkOutput("buf_pc", pc_out, 32'h200);
      applyStimulus(1, 0, 1, 1, 32'h20, 0, 0, 0);
      applyStimulus(1, 1, 1, 1, 32'h100, 0, 0, 0);
      applyStimulus(1, 1, 1, 1, 32'h200, 0, 0, 0);
      applyStimulus(1, 0, 1, 1, 32'h300, 0, 0, 0);
      checkOutput("new_beats_buf", pc_out, 32'h300);

      // misaligned target traps even under stall; pulse lasts one cycle
      applyStimulus(1, 1, 1, 1, 32'h400, 0, 0, 0);
      applyStimulus(1, 1, 1, 1, 32'h102, 0, 0, 0);
      checkOutput("mis_pc", pc_out, 32'h80);
      checkOutput("mis_epc", epc, 32'h102);
      checkOutput("mis_pulse", misalign, 1'b1);
      checkOutput("mis_pend", pend_valid, 1'b0);
      applyStimulus(1, 1, 1, 0, 0, 0, 0, 0);
      checkOutput("mis_drop", misalign, 1'b0);

      // address wrap
      applyStimulus(1, 0, 1, 1, 32'hFFFF_FFFC, 0, 0, 0);
      applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
      checkOutput("wrap_pc", pc_out, 32'h0);

      // halt freezes, trap releases; same-edge halt+trap stays in RUN
      applyStimulus(1, 0, 1, 1, 32'h40, 0, 0, 0);
      applyStimulus(1, 1, 1, 0, 0, 0, 1, 0);
      for (int i = 0; i < 5; i++) applyStimulus(1, 0, 1, 1, 32'h600, 0, 0, 0);
      checkOutput("halt_pc", pc_out, 32'h40);
      applyStimulus(1, 0, 1, 0, 0, 1, 0, 0);
      checkOutput("halt_trap_pc", pc_out, 32'h80);
      checkOutput("halt_trap_epc", epc, 32'h40);
      applyStimulus(1, 0, 1, 0, 0, 1, 1, 0);
      applyStimulus(1, 0, 1, 0, 0, 0, 0, 0);
      checkOutput("halt_trap_run", pc_out, 32'h84);

      // clear while halted with a buffered redirect
      applyStimulus(1, 1, 1, 1, 32'h500, 0, 1, 0);
      checkOutput("pre_clr_pend", pend_valid, 1'b1);
      applyStimulus(0, 0, 1, 0, 0, 0, 0, 1);
      checkOutput("clr_pc", pc_out, RST_PC);
      checkOutput("clr_cnt", fetch_cnt, 32'd0);
      applyStimulus(1, 0, 1, 0, 0, 0, 0, 1);
      checkOutput("clr_boot_req", imem_req, 1'b0);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] t;
         t = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                         : ($urandom & 32'h0000_0FFF);
         if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
         applyStimulus($urandom_range(0, 99) != 0,
                       $urandom_range(0, 2) == 0,
                       $urandom_range(0, 2) != 0,
                       $urandom_range(0, 3) == 0,
                       t,
                       $urandom_range(0, 15) == 0,
                       $urandom_range(0, 15) == 0,
                       $urandom_range(0, 3) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
